// File: rtl/bin_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
// A start in IDLE launches an 8-cycle conversion; done pulses once when bcd updates.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_sr;
    logic [11:0] r_scratch;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic        r_busy;
    logic        r_done;
    logic [11:0] w_scratch_nxt;
    logic        w_last_shift;

    function automatic logic [3:0] digit_adj(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Correct every digit first, then shift the next binary bit into the ones digit.
    function automatic logic [11:0] dabble_step(input logic [11:0] s, input logic b);
        logic [11:0] a;
        a = {digit_adj(s[11:8]), digit_adj(s[7:4]), digit_adj(s[3:0])};
        return {a[10:0], b};
    endfunction

    assign w_scratch_nxt = dabble_step(r_scratch, r_sr[7]);
    assign w_last_shift  = (r_cnt == 3'd7);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (w_last_shift) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: operand capture, dabble steps and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= 8'h00;
            r_scratch <= 12'h000;
            r_cnt     <= 3'd0;
            r_bcd     <= 12'h000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr      <= bin;
                        r_scratch <= 12'h000;
                        r_cnt     <= 3'd0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_scratch_nxt;
                    r_sr      <= {r_sr[6:0], 1'b0};
                    r_cnt     <= r_cnt + 3'd1;
                    // bcd only ever takes the finished value, never a partial one
                    if (w_last_shift) begin
                        r_bcd  <= w_scratch_nxt;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign done = r_done;

endmodule
